id_stage: RTL and testbench

//   Decode stage; consumes IFPC/IFInsn/IFEn from if_stage and feeds EX. Decodes the instruction,

---
 rtl/id_stage.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: instruction decode, GPR operand forwarding, branch resolution
// and load-use interlock, with a single registered ID/EX boundary.

module id_fwd (
  input  logic [4:0]  rd_addr,
  input  logic [31:0] gpr_data,
  input  logic        ex_en,
  input  logic        ex_gpr_we_,
  input  logic [4:0]  ex_dst,
  input  logic        ex_is_load,
  input  logic [31:0] ex_data,
  input  logic        mem_en,
  input  logic        mem_gpr_we_,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_data,
  output logic [31:0] data,
  output logic        load_hit
);
  logic ex_wr, mem_wr;

  assign ex_wr    = ex_en & ~ex_gpr_we_ & (ex_dst == rd_addr);
  assign mem_wr   = mem_en & ~mem_gpr_we_ & (mem_dst == rd_addr);
  // A load in EX has no data yet; it raises the interlock instead of forwarding.
  assign load_hit = ex_wr & ex_is_load;
  assign data     = (ex_wr & ~ex_is_load) ? ex_data :
                    mem_wr                ? mem_data : gpr_data;
endmodule

module id_stage (
  input  logic        clk,
  input  logic        reset_,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [29:0] IFPC,
  input  logic [31:0] IFInsn,
  input  logic        IFEn,
  output logic [4:0]  GprRdAddr0,
  output logic [4:0]  GprRdAddr1,
  input  logic [31:0] GprRdData0,
  input  logic [31:0] GprRdData1,
  input  logic        ExEn,
  input  logic        ExGprWe_,
  input  logic [4:0]  ExDst,
  input  logic        ExIsLoad,
  input  logic [31:0] ExFwdData,
  input  logic        MemEn,
  input  logic        MemGprWe_,
  input  logic [4:0]  MemDst,
  input  logic [31:0] MemFwdData,
  output logic        BrTaken,
  output logic [29:0] BrAddr,
  output logic        LoadHazard,
  output logic [29:0] IDPC,
  output logic        IDEn,
  output logic [3:0]  IDAluOp,
  output logic [31:0] IDAluIn0,
  output logic [31:0] IDAluIn1,
  output logic [4:0]  IDDst,
  output logic        IDGprWe_,
  output logic [1:0]  IDMemOp,
  output logic [31:0] IDMemWrData,
  output logic        IDIllegal
);
  localparam logic [5:0] OP_ADD = 6'h01, OP_ADDI = 6'h02, OP_SUB = 6'h03,
                         OP_AND = 6'h04, OP_OR   = 6'h05, OP_XOR = 6'h06,
                         OP_LDW = 6'h10, OP_STW  = 6'h11, OP_BE  = 6'h18,
                         OP_BNE = 6'h19, OP_JR   = 6'h1A, OP_NOP = 6'h3F;

  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                         ALU_AND  = 4'd3, ALU_OR  = 4'd4, ALU_XOR = 4'd5;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] dst;
    logic       gpr_we_;
    logic [1:0] mem_op;
    logic       illegal;
    logic       imm_b;
    logic       rd_ra;
    logic       rd_rb;
    logic       be;
    logic       bne;
    logic       jr;
  } dec_t;

  logic [5:0]       op;
  logic [4:0]       ra, rb, rc;
  logic [31:0]      sext;
  dec_t             dec;
  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] gpr_rd;
  logic [1:0][31:0] fwd;
  logic [1:0]       load_hit;
  logic             eq, cond, capture;

  assign op   = IFInsn[31:26];
  assign ra   = IFInsn[25:21];
  assign rb   = IFInsn[20:16];
  assign rc   = IFInsn[15:11];
  assign sext = {{16{IFInsn[15]}}, IFInsn[15:0]};

  always_comb begin
    dec = '{alu_op: ALU_NONE, dst: 5'd0, gpr_we_: 1'b1, mem_op: 2'd0,
            illegal: 1'b0, imm_b: 1'b0, rd_ra: 1'b0, rd_rb: 1'b0,
            be: 1'b0, bne: 1'b0, jr: 1'b0};
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        dec.dst     = rc;
        dec.gpr_we_ = 1'b0;
        dec.rd_ra   = 1'b1;
        dec.rd_rb   = 1'b1;
        case (op)
          OP_ADD:  dec.alu_op = ALU_ADD;
          OP_SUB:  dec.alu_op = ALU_SUB;
          OP_AND:  dec.alu_op = ALU_AND;
          OP_OR:   dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_XOR;
        endcase
      end
      OP_ADDI, OP_LDW: begin
        dec.alu_op  = ALU_ADD;
        dec.dst     = rb;
        dec.gpr_we_ = 1'b0;
        dec.imm_b   = 1'b1;
        dec.rd_ra   = 1'b1;
        dec.mem_op  = (op == OP_LDW) ? 2'd1 : 2'd0;
      end
      OP_STW: begin
        dec.alu_op = ALU_ADD;
        dec.imm_b  = 1'b1;
        dec.mem_op = 2'd2;
        dec.rd_ra  = 1'b1;
        dec.rd_rb  = 1'b1;
      end
      OP_BE, OP_BNE: begin
        dec.be    = (op == OP_BE);
        dec.bne   = (op == OP_BNE);
        dec.rd_ra = 1'b1;
        dec.rd_rb = 1'b1;
      end
      OP_JR: begin
        dec.jr    = 1'b1;
        dec.rd_ra = 1'b1;
      end
      OP_NOP:  ;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign GprRdAddr0 = ra;
  assign GprRdAddr1 = rb;
  assign src_addr   = {rb, ra};
  assign gpr_rd     = {GprRdData1, GprRdData0};

  for (genvar i = 0; i < 2; i++) begin : g_src
    id_fwd u_fwd (
      .rd_addr    (src_addr[i]),
      .gpr_data   (gpr_rd[i]),
      .ex_en      (ExEn),
      .ex_gpr_we_ (ExGprWe_),
      .ex_dst     (ExDst),
      .ex_is_load (ExIsLoad),
      .ex_data    (ExFwdData),
      .mem_en     (MemEn),
      .mem_gpr_we_(MemGprWe_),
      .mem_dst    (MemDst),
      .mem_data   (MemFwdData),
      .data       (fwd[i]),
      .load_hit   (load_hit[i])
    );
  end

  assign LoadHazard = IFEn & ((dec.rd_ra & load_hit[0]) | (dec.rd_rb & load_hit[1]));

  assign eq      = (fwd[0] == fwd[1]);
  assign cond    = (dec.be & eq) | (dec.bne & ~eq) | dec.jr;
  assign BrTaken = IFEn & ~LoadHazard & cond;
  assign BrAddr  = dec.jr ? fwd[0][31:2] : (IFPC + 30'd1 + sext[29:0]);

  assign capture = IFEn & ~LoadHazard;

  // Bubbles only clear the fields that can cause side effects downstream.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      IDPC        <= '0;
      IDEn        <= 1'b0;
      IDAluOp     <= '0;
      IDAluIn0    <= '0;
      IDAluIn1    <= '0;
      IDDst       <= '0;
      IDGprWe_    <= 1'b1;
      IDMemOp     <= '0;
      IDMemWrData <= '0;
      IDIllegal   <= 1'b0;
    end else if (Flush || (!Stall && !capture)) begin
      IDEn      <= 1'b0;
      IDGprWe_  <= 1'b1;
      IDMemOp   <= '0;
      IDIllegal <= 1'b0;
    end else if (!Stall) begin
      IDPC        <= IFPC;
      IDEn        <= 1'b1;
      IDAluOp     <= dec.alu_op;
      IDAluIn0    <= fwd[0];
      IDAluIn1    <= dec.imm_b ? sext : fwd[1];
      IDDst       <= dec.dst;
      IDGprWe_    <= dec.gpr_we_;
      IDMemOp     <= dec.mem_op;
      IDMemWrData <= fwd[1];
      IDIllegal   <= dec.illegal;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: decode, forwarding, interlock, branches,
// stall/flush and illegal opcodes against hand-computed values.

module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset_;
  logic        Stall, Flush;
  logic [29:0] IFPC;
  logic [31:0] IFInsn;
  logic        IFEn;
  logic [4:0]  GprRdAddr0, GprRdAddr1;
  logic [31:0] GprRdData0, GprRdData1;
  logic        ExEn, ExGprWe_, ExIsLoad;
  logic [4:0]  ExDst;
  logic [31:0] ExFwdData;
  logic        MemEn, MemGprWe_;
  logic [4:0]  MemDst;
  logic [31:0] MemFwdData;
  logic        BrTaken, LoadHazard;
  logic [29:0] BrAddr;
  logic [29:0] IDPC;
  logic        IDEn, IDGprWe_, IDIllegal;
  logic [3:0]  IDAluOp;
  logic [31:0] IDAluIn0, IDAluIn1, IDMemWrData;
  logic [4:0]  IDDst;
  logic [1:0]  IDMemOp;

  logic [31:0] gpr [32];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign GprRdData0 = gpr[GprRdAddr0];
  assign GprRdData1 = gpr[GprRdAddr1];

  id_stage dut (
    .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush),
    .IFPC(IFPC), .IFInsn(IFInsn), .IFEn(IFEn),
    .GprRdAddr0(GprRdAddr0), .GprRdAddr1(GprRdAddr1),
    .GprRdData0(GprRdData0), .GprRdData1(GprRdData1),
    .ExEn(ExEn), .ExGprWe_(ExGprWe_), .ExDst(ExDst), .ExIsLoad(ExIsLoad),
    .ExFwdData(ExFwdData),
    .MemEn(MemEn), .MemGprWe_(MemGprWe_), .MemDst(MemDst), .MemFwdData(MemFwdData),
    .BrTaken(BrTaken), .BrAddr(BrAddr), .LoadHazard(LoadHazard),
    .IDPC(IDPC), .IDEn(IDEn), .IDAluOp(IDAluOp), .IDAluIn0(IDAluIn0),
    .IDAluIn1(IDAluIn1), .IDDst(IDDst), .IDGprWe_(IDGprWe_), .IDMemOp(IDMemOp),
    .IDMemWrData(IDMemWrData), .IDIllegal(IDIllegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] a, b, c);
    return {op, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] a, b,
                                        input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic ex_set(input logic en, input logic [4:0] dst, input logic ld,
                        input logic [31:0] d);
    ExEn = en; ExGprWe_ = ~en; ExDst = dst; ExIsLoad = ld; ExFwdData = d;
  endtask

  task automatic mem_set(input logic en, input logic [4:0] dst, input logic [31:0] d);
    MemEn = en; MemGprWe_ = ~en; MemDst = dst; MemFwdData = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    gpr[1] = 32'd5; gpr[2] = 32'd7; gpr[4] = 32'd40; gpr[8] = 32'h0000_1234;
    reset_ = 1'b0; Stall = 1'b0; Flush = 1'b0;
    IFPC = 30'h40; IFEn = 1'b1; IFInsn = r_ins(6'h01, 5'd1, 5'd2, 5'd3);
    ex_set(1'b0, 5'd0, 1'b0, 32'h0);
    mem_set(1'b0, 5'd0, 32'h0);

    // Reset
    step(); step();
    chk("rst_en",    IDEn, 0);
    chk("rst_we",    IDGprWe_, 1);
    chk("rst_memop", IDMemOp, 0);
    chk("rst_ill",   IDIllegal, 0);
    chk("rst_br",    BrTaken, 0);
    reset_ = 1'b1;

    // ADD r3,r1,r2 with EX forwarding r2=9
    ex_set(1'b1, 5'd2, 1'b0, 32'd9);
    #1;
    chk("add_ra_addr", GprRdAddr0, 1);
    chk("add_rb_addr", GprRdAddr1, 2);
    chk("add_lh",      LoadHazard, 0);
    step();
    chk("add_en",  IDEn, 1);
    chk("add_in0", IDAluIn0, 5);
    chk("add_in1", IDAluIn1, 9);
    chk("add_dst", IDDst, 3);
    chk("add_op",  IDAluOp, 1);
    chk("add_we",  IDGprWe_, 0);
    chk("add_pc",  IDPC, 32'h40);

    // SUB r6,r1,r2: ra from EX, rb from MEM
    IFInsn = r_ins(6'h03, 5'd1, 5'd2, 5'd6);
    ex_set(1'b1, 5'd1, 1'b0, 32'd11);
    mem_set(1'b1, 5'd2, 32'd22);
    step();
    chk("sub_in0", IDAluIn0, 11);
    chk("sub_in1", IDAluIn1, 22);
    chk("sub_op",  IDAluOp, 2);
    chk("sub_dst", IDDst, 6);

    // OR r7,r1,r1: both stages hit r1, EX wins
    IFInsn = r_ins(6'h05, 5'd1, 5'd1, 5'd7);
    mem_set(1'b1, 5'd1, 32'd22);
    step();
    chk("prio_in0", IDAluIn0, 11);
    chk("prio_in1", IDAluIn1, 11);
    chk("or_op",    IDAluOp, 4);
    mem_set(1'b0, 5'd0, 32'h0);

    // Load-use: LDW r4 in EX, ADD r5,r4,r1 in IF
    ex_set(1'b1, 5'd4, 1'b1, 32'hDEAD);
    IFInsn = r_ins(6'h01, 5'd4, 5'd1, 5'd5);
    #1;
    chk("lu_hazard", LoadHazard, 1);
    step();
    chk("lu_bubble_en", IDEn, 0);
    chk("lu_bubble_we", IDGprWe_, 1);
    ex_set(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk("lu_clear", LoadHazard, 0);
    step();
    chk("lu_en",  IDEn, 1);
    chk("lu_in0", IDAluIn0, 40);
    chk("lu_in1", IDAluIn1, 5);
    chk("lu_dst", IDDst, 5);

    // ADDI r4,r1,-1 reads only ra: load to r4 in EX is no hazard
    ex_set(1'b1, 5'd4, 1'b1, 32'hDEAD);
    IFInsn = i_ins(6'h02, 5'd1, 5'd4, 16'hFFFF);
    #1;
    chk("addi_lh", LoadHazard, 0);
    step();
    chk("addi_in0", IDAluIn0, 5);
    chk("addi_in1", IDAluIn1, 32'hFFFF_FFFF);
    chk("addi_dst", IDDst, 4);
    chk("addi_op",  IDAluOp, 1);

    // JR r4 blocked by the load interlock
    IFInsn = i_ins(6'h1A, 5'd4, 5'd0, 16'h0);
    #1;
    chk("jr_lh",  LoadHazard, 1);
    chk("jr_lbr", BrTaken, 0);
    ex_set(1'b0, 5'd0, 1'b0, 32'h0);

    // JR r8
    IFInsn = i_ins(6'h1A, 5'd8, 5'd0, 16'h0);
    #1;
    chk("jr_br",   BrTaken, 1);
    chk("jr_addr", BrAddr, 32'h48D);

    // BE r1,r2,-2 at 0x100
    gpr[2] = 32'd5;
    IFPC = 30'h100;
    IFInsn = i_ins(6'h18, 5'd1, 5'd2, 16'hFFFE);
    #1;
    chk("be_taken", BrTaken, 1);
    chk("be_addr",  BrAddr, 32'h0FF);
    IFEn = 1'b0;
    #1;
    chk("be_noen", BrTaken, 0);
    IFEn = 1'b1;
    step();
    chk("be_op", IDAluOp, 0);
    chk("be_we", IDGprWe_, 1);
    chk("be_en", IDEn, 1);
    gpr[2] = 32'd7;
    #1;
    chk("be_nt", BrTaken, 0);
    IFInsn = i_ins(6'h19, 5'd1, 5'd2, 16'h0004);
    #1;
    chk("bne_taken", BrTaken, 1);
    chk("bne_addr",  BrAddr, 32'h105);

    // STW r2 -> [r1+4], then LDW r9 <- [r1+8]
    IFInsn = i_ins(6'h11, 5'd1, 5'd2, 16'h0004);
    step();
    chk("stw_memop", IDMemOp, 2);
    chk("stw_wdata", IDMemWrData, 7);
    chk("stw_we",    IDGprWe_, 1);
    chk("stw_in1",   IDAluIn1, 4);
    IFInsn = i_ins(6'h10, 5'd1, 5'd9, 16'h0008);
    step();
    chk("ldw_memop", IDMemOp, 1);
    chk("ldw_dst",   IDDst, 9);
    chk("ldw_we",    IDGprWe_, 0);

    // Stall holds while IF changes
    IFInsn = r_ins(6'h01, 5'd1, 5'd2, 5'd3);
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IFInsn = r_ins(6'h06, 5'd4, 5'd8, 5'(10 + i));
      step();
      chk("stall_dst", IDDst, 3);
      chk("stall_in1", IDAluIn1, 7);
      chk("stall_op",  IDAluOp, 1);
      chk("stall_en",  IDEn, 1);
    end
    Flush = 1'b1;
    step();
    chk("flush_en", IDEn, 0);
    chk("flush_we", IDGprWe_, 1);
    Stall = 1'b0; Flush = 1'b0;

    // Illegal opcode
    IFInsn = {6'h2A, 26'h0};
    step();
    chk("ill_flag",  IDIllegal, 1);
    chk("ill_en",    IDEn, 1);
    chk("ill_we",    IDGprWe_, 1);
    chk("ill_memop", IDMemOp, 0);

    // IFEn low gives a bubble
    IFEn = 1'b0;
    IFInsn = r_ins(6'h01, 5'd1, 5'd2, 5'd3);
    step();
    chk("noen_en",  IDEn, 0);
    chk("noen_ill", IDIllegal, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
